// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: MIPS opcode constants and FSM state encoding.
package mem_stage_pkg;

  localparam logic [0:5] SPECIAL = 6'b000000;
  localparam logic [0:5] REGIMM  = 6'b000001;
  localparam logic [0:5] J       = 6'b000010;
  localparam logic [0:5] BEQ     = 6'b000100;
  localparam logic [0:5] BNE     = 6'b000101;
  localparam logic [0:5] BLEZ    = 6'b000110;
  localparam logic [0:5] BGTZ    = 6'b000111;
  localparam logic [0:5] ADDIU   = 6'b001001;
  localparam logic [0:5] SLTI    = 6'b001010;
  localparam logic [0:5] ORI     = 6'b001101;
  localparam logic [0:5] LUI     = 6'b001111;
  localparam logic [0:5] LW      = 6'b100011;
  localparam logic [0:5] SW      = 6'b101011;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_dest_decode.sv
// Combinational destination-register decode; shared with hazard-detection logic.
module mem_dest_decode
  import mem_stage_pkg::*;
(
  input  logic [0:31] i_insn,
  output logic [0:4]  o_dest,
  output logic        o_reg_write,
  output logic        o_is_load,
  output logic        o_is_store
);

  logic [0:5] w_op;
  logic       w_writes;
  logic       w_unused_bits;

  assign w_op          = i_insn[0:5];
  assign w_unused_bits = ^{i_insn[6:10], i_insn[21:31]};

  always_comb begin
    o_dest   = i_insn[11:15];
    w_writes = 1'b0;
    case (w_op)
      SPECIAL: begin
        o_dest   = i_insn[16:20];
        w_writes = 1'b1;
      end
      ADDIU, SLTI, ORI, LUI, LW: w_writes = 1'b1;
      default: w_writes = 1'b0;
    endcase
  end

  // $zero is never a real writeback target.
  assign o_reg_write = w_writes && (o_dest != 5'd0);
  assign o_is_load   = (w_op == LW);
  assign o_is_store  = (w_op == SW);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: LW/SW via a req/ack data-memory port, pass-through for other ops.
// Handshake: dmem_req rises with a stable addr/we/wdata and holds until an edge samples dmem_ack=1
// (or the wait times out); dmem_ack is ignored whenever dmem_req is low.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [0:31] in_insn,
  input  logic [0:31] in_alu_data,
  input  logic [0:31] in_rt_data,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [0:31] dmem_rdata,
  output logic        out_valid,
  output logic [0:31] out_data,
  output logic [0:4]  out_dest,
  output logic        out_reg_write,
  output logic        out_err,
  output logic        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_req, w_req_nx;
  logic              r_we, w_we_nx;
  logic [0:31]       r_addr, w_addr_nx;
  logic [0:31]       r_wdata, w_wdata_nx;
  logic              r_ov, w_ov_nx;
  logic [0:31]       r_od, w_od_nx;
  logic [0:4]        r_dest, w_dest_nx;
  logic              r_rw, w_rw_nx;
  logic              r_err, w_err_nx;
  logic [0:4]        r_pend_dest, w_pend_dest_nx;
  logic              r_pend_rw, w_pend_rw_nx;
  logic              r_pend_load, w_pend_load_nx;

  logic [0:4]        w_dec_dest;
  logic              w_dec_rw;
  logic              w_dec_load;
  logic              w_dec_store;
  logic              w_misaligned;

  mem_dest_decode u_dest_decode (
    .i_insn      (in_insn),
    .o_dest      (w_dec_dest),
    .o_reg_write (w_dec_rw),
    .o_is_load   (w_dec_load),
    .o_is_store  (w_dec_store)
  );

  assign w_misaligned = (in_alu_data[30:31] != 2'b00);

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_req_nx       = r_req;
    w_we_nx        = r_we;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_ov_nx        = 1'b0;
    w_od_nx        = r_od;
    w_dest_nx      = r_dest;
    w_rw_nx        = r_rw;
    w_err_nx       = r_err;
    w_pend_dest_nx = r_pend_dest;
    w_pend_rw_nx   = r_pend_rw;
    w_pend_load_nx = r_pend_load;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if ((w_dec_load || w_dec_store) && !w_misaligned) begin
            w_state_nx     = ACCESS;
            w_cnt_nx       = '0;
            w_req_nx       = 1'b1;
            w_we_nx        = w_dec_store;
            w_addr_nx      = in_alu_data;
            w_wdata_nx     = w_dec_store ? in_rt_data : r_wdata;
            w_pend_dest_nx = w_dec_dest;
            w_pend_rw_nx   = w_dec_rw;
            w_pend_load_nx = w_dec_load;
          end else begin
            // Pass-through, or a misaligned access rejected without touching memory.
            w_ov_nx   = 1'b1;
            w_od_nx   = in_alu_data;
            w_dest_nx = w_dec_dest;
            w_err_nx  = w_dec_load || w_dec_store;
            w_rw_nx   = w_dec_rw && !(w_dec_load || w_dec_store);
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          w_state_nx = IDLE;
          w_req_nx   = 1'b0;
          w_ov_nx    = 1'b1;
          w_err_nx   = 1'b0;
          w_dest_nx  = r_pend_dest;
          w_rw_nx    = r_pend_load && r_pend_rw;
          w_od_nx    = r_pend_load ? dmem_rdata : r_addr;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nx = IDLE;
          w_req_nx   = 1'b0;
          w_ov_nx    = 1'b1;
          w_err_nx   = 1'b1;
          w_dest_nx  = r_pend_dest;
          w_rw_nx    = 1'b0;
          w_od_nx    = r_addr;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ov        <= 1'b0;
      r_od        <= '0;
      r_dest      <= '0;
      r_rw        <= 1'b0;
      r_err       <= 1'b0;
      r_pend_dest <= '0;
      r_pend_rw   <= 1'b0;
      r_pend_load <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_req       <= w_req_nx;
      r_we        <= w_we_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_ov        <= w_ov_nx;
      r_od        <= w_od_nx;
      r_dest      <= w_dest_nx;
      r_rw        <= w_rw_nx;
      r_err       <= w_err_nx;
      r_pend_dest <= w_pend_dest_nx;
      r_pend_rw   <= w_pend_rw_nx;
      r_pend_load <= w_pend_load_nx;
    end
  end

  assign stall         = (r_state == ACCESS);
  assign dbg_state     = r_state;
  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_wdata    = r_wdata;
  assign out_valid     = r_ov;
  assign out_data      = r_od;
  assign out_dest      = r_dest;
  assign out_reg_write = r_rw;
  assign out_err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a transaction-level reference model and scoreboard.
module tb_mem_stage;

  localparam int TO = 16;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [0:31] in_insn = '0;
  logic [0:31] in_alu_data = '0;
  logic [0:31] in_rt_data = '0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [0:31] dmem_addr;
  logic [0:31] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [0:31] dmem_rdata = '0;
  logic        out_valid;
  logic [0:31] out_data;
  logic [0:4]  out_dest;
  logic        out_reg_write;
  logic        out_err;
  logic        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  // {check_data, err, reg_write, dest[4:0], data[31:0]}
  logic [39:0] exp_q[$];

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_insn       (in_insn),
    .in_alu_data   (in_alu_data),
    .in_rt_data    (in_rt_data),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_dest      (out_dest),
    .out_reg_write (out_reg_write),
    .out_err       (out_err),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rd);
    logic [4:0]  rs;
    logic [10:0] tail;
    rs   = 5'($urandom);
    tail = 11'($urandom);
    return {op, rs, rt, rd, tail};
  endfunction

  // Reference decode written from the opcode table.
  function automatic void model_decode(input logic [31:0] insn, output logic [4:0] dest,
                                       output logic rw);
    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    op = insn[31:26];
    rt = insn[20:16];
    rd = insn[15:11];
    dest = (op == OP_SPECIAL) ? rd : rt;
    rw = (op == OP_SPECIAL) || (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_ORI) ||
         (op == OP_LUI) || (op == OP_LW);
    if (dest == 5'd0) rw = 1'b0;
  endfunction

  // Driver: issue one instruction, act as memory (ack in ACCESS cycle ack_at; 0 = never),
  // then score the resulting pulse.
  task automatic run_insn(input logic [31:0] insn, input logic [31:0] alu,
                          input logic [31:0] rt, input int ack_at, input logic [31:0] rdata);
    logic [5:0]  op;
    logic        is_ld, is_st, is_mem, mis, tmo, err, rw;
    logic [4:0]  dest;
    logic [31:0] exp_data;
    logic [39:0] e;
    int          exp_lat;
    int          n;
    op     = insn[31:26];
    is_ld  = (op == OP_LW);
    is_st  = (op == OP_SW);
    is_mem = is_ld || is_st;
    mis    = (alu % 4) != 0;
    tmo    = is_mem && !mis && (ack_at == 0 || ack_at > TO);
    err    = is_mem && (mis || tmo);
    model_decode(insn, dest, rw);
    rw       = rw && !err;
    exp_data = (is_ld && !mis && !tmo) ? rdata : alu;
    exp_lat  = (!is_mem || mis) ? 1 : (tmo ? TO + 1 : ack_at + 1);
    exp_q.push_back({!tmo, err, rw, dest, exp_data});

    @(negedge clock);
    in_valid    = 1'b1;
    in_insn     = insn;
    in_alu_data = alu;
    in_rt_data  = rt;
    @(posedge clock);
    #1;
    in_valid    = 1'b0;
    in_insn     = $urandom;
    in_alu_data = $urandom;
    in_rt_data  = $urandom;
    n = 1;
    while (!out_valid && n <= TO + 4) begin
      check("stall_access", stall, 1);
      check("req_access", dmem_req, 1);
      check("addr_access", dmem_addr, alu);
      check("we_access", dmem_we, is_st);
      if (is_st) check("wdata_access", dmem_wdata, rt);
      dmem_ack   = (n == ack_at);
      dmem_rdata = (n == ack_at) ? rdata : $urandom;
      @(posedge clock);
      #1;
      dmem_ack = 1'b0;
      n++;
    end
    if (!out_valid) begin
      check("out_valid_seen", 0, 1);
    end else begin
      check("latency", n, exp_lat);
      check("stall_after", stall, 0);
      check("req_after", dmem_req, 0);
      // Scoreboard
      e = exp_q.pop_front();
      check("out_err", out_err, e[38]);
      check("out_reg_write", out_reg_write, e[37]);
      if (e[37]) check("out_dest", out_dest, e[36:32]);
      if (e[39]) check("out_data", out_data, e[31:0]);
    end
    @(posedge clock);
    #1;
    check("pulse_width", out_valid, 0);
  endtask

  initial begin
    logic [5:0]  ops[10];
    logic [31:0] alu;
    logic [31:0] insn;
    ops = '{OP_SPECIAL, OP_ADDIU, OP_SLTI, OP_LUI, OP_LW, OP_LW, OP_SW, OP_SW, OP_BEQ, OP_J};

    // Reset state
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_dest", out_dest, 0);
    check("rst_rw", out_reg_write, 0);
    check("rst_err", out_err, 0);
    check("rst_stall", stall, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed cases
    run_insn(mk_insn(OP_ADDIU, 5'd5, 5'd0), 32'h0000_002A, 32'h0, 0, 32'h0);
    run_insn(mk_insn(OP_LW, 5'd8, 5'd0), 32'h0000_0100, 32'h0, 3, 32'hCAFE_F00D);
    run_insn(mk_insn(OP_SW, 5'd9, 5'd0), 32'h0000_0200, 32'hDEAD_BEEF, 1, 32'h1234_5678);
    run_insn(mk_insn(OP_LW, 5'd8, 5'd0), 32'h0000_0102, 32'h0, 1, 32'h0);
    run_insn(mk_insn(OP_LW, 5'd7, 5'd0), 32'h0000_0300, 32'h0, 0, 32'h0);
    run_insn(mk_insn(OP_ORI, 5'd6, 5'd0), 32'h0000_FFFF, 32'h0, 0, 32'h0);
    run_insn(mk_insn(OP_LW, 5'd3, 5'd0), 32'h0000_0400, 32'h0, TO, 32'h0BAD_CAFE);
    run_insn(mk_insn(OP_SPECIAL, 5'd4, 5'd0), 32'h1111_2222, 32'h0, 0, 32'h0);

    // Ack while idle must be ignored
    @(negedge clock);
    dmem_ack = 1'b1;
    @(posedge clock);
    #1;
    dmem_ack = 1'b0;
    check("idle_ack_valid", out_valid, 0);
    check("idle_ack_req", dmem_req, 0);

    // Back-to-back pass-through accepts
    @(negedge clock);
    in_valid    = 1'b1;
    in_insn     = mk_insn(OP_ADDIU, 5'd3, 5'd0);
    in_alu_data = 32'hA5A5_0001;
    @(posedge clock);
    #1;
    check("b2b_valid0", out_valid, 1);
    check("b2b_data0", out_data, 32'hA5A5_0001);
    in_insn     = mk_insn(OP_ORI, 5'd4, 5'd0);
    in_alu_data = 32'h5A5A_0002;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("b2b_valid1", out_valid, 1);
    check("b2b_data1", out_data, 32'h5A5A_0002);
    check("b2b_dest1", out_dest, 4);
    @(posedge clock);
    #1;
    check("b2b_idle", out_valid, 0);

    // Asynchronous reset in the middle of an access
    @(negedge clock);
    in_valid    = 1'b1;
    in_insn     = mk_insn(OP_LW, 5'd10, 5'd0);
    in_alu_data = 32'h0000_0800;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("pre_rst_req", dmem_req, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_req", dmem_req, 0);
    check("async_rst_stall", stall, 0);
    @(posedge clock);
    #1;
    check("async_rst_valid", out_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_insn(mk_insn(OP_SPECIAL, 5'd12, 5'd0), 32'h0000_0077, 32'h0, 0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op   = ops[$urandom_range(0, 9)];
      insn = mk_insn(op, 5'($urandom), 5'($urandom));
      alu  = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      run_insn(insn, alu, $urandom, $urandom_range(0, TO + 2), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU.
- Consumes the ALU result (`outData`), the forwarded rt operand and the instruction word.
- Performs LW/SW through a req/ack data-memory handshake. Passes all other results through to writeback with destination-register decode.
- Stalls upstream while a memory access is outstanding. Flags misaligned and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, ACCESS cycles without dmem_ack before abort (>=1)
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents an instruction this cycle
in_insn  in  [0:31]  instruction word; opcode = [0:5], rt = [11:15], rd = [16:20]
in_alu_data  in  [0:31]  ALU result: memory address for LW/SW, otherwise the result
in_rt_data  in  [0:31]  store data for SW
stall  out  1  combinational; 1 while state==ACCESS. Upstream holds inputs.
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write (SW), 0 = read (LW)
dmem_addr  out  [0:31]  word address, registered
dmem_wdata  out  [0:31]  store data, registered
dmem_ack  in  1  memory completion, sampled at posedge
dmem_rdata  in  [0:31]  load data, valid when dmem_ack=1
out_valid  out  1  one-cycle pulse: result available for writeback
out_data  out  [0:31]  load data or passed-through ALU result
out_dest  out  [0:4]  destination register
out_reg_write  out  1  writeback enable
out_err  out  1  this result is misaligned or timed out; out_reg_write forced 0

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; counter=0.
  - dmem_req, dmem_we, out_valid, out_reg_write and out_err are 0.
  - dmem_addr, dmem_wdata, out_data and out_dest are 0.
  - A reset mid-ACCESS drops dmem_req immediately, and no result is emitted.
- Destination decode:
  - opcode 000000 (SPECIAL): dest = rd.
  - ADDIU (001001), SLTI (001010), ORI (001101), LUI (001111), LW (100011): dest = rt.
  - SW, branches (BEQ/BNE/BLEZ/BGTZ/REGIMM) and J: reg_write = 0.
  - dest == 0 always forces reg_write = 0.
- Accept: at posedge with state==IDLE and in_valid=1.
- IDLE, non-memory op:
  - Next edge: out_valid=1, out_data=in_alu_data, out_dest/out_reg_write per decode, out_err=0.
  - Latency 1 cycle. Back-to-back accepts produce consecutive pulses.
- IDLE, LW/SW with in_alu_data[30:31] != 00 (misaligned):
  - No request.
  - Next edge: out_valid=1, out_err=1, out_reg_write=0, out_data=in_alu_data.
- IDLE, aligned LW/SW:
  - Register dmem_addr=in_alu_data, dmem_wdata=in_rt_data (SW), dmem_we=(SW).
  - Set dmem_req=1 and counter=0, then go to ACCESS. The target register is latched.
- ACCESS:
  - dmem_req, addr, we and wdata are held stable; stall=1; in_valid is ignored.
  - dmem_ack=1 at an edge:
    - Drop req; go to IDLE.
    - out_valid=1, out_err=0.
    - LW: out_data=dmem_rdata, out_reg_write per decode.
    - SW: out_reg_write=0, out_data=dmem_addr.
  - dmem_ack=0: counter increments. On the edge where counter reaches TIMEOUT_CYCLES-1 and ack is still 0:
    - Drop req; go to IDLE.
    - out_valid=1, out_err=1, out_reg_write=0.
- Timing:
  - Load/store minimum latency is 2 cycles, accept to out_valid (ack in the first ACCESS cycle).
  - An ack arriving on the timeout edge wins (normal completion).
- Next-instruction rules:
  - stall falls in the cycle after the completion edge, and the next instruction is accepted at the following edge.
  - No accept occurs on the completion edge itself.
- dmem_ack while IDLE is ignored.
- out_valid is a single-cycle pulse. out_data, out_dest and out_err hold until the next pulse.

Decomposition:
- Shared package/header, alongside `control.vh`/`alu_func.vh`:
  - opcode constants LW, SW, ADDIU, SLTI, ORI, LUI, J, BEQ, BNE, BLEZ, BGTZ, REGIMM;
  - FSM state encoding IDLE/ACCESS.
- One natural sub-module: mem_dest_decode. It is combinational: insn in, dest/reg_write/is_load/is_store out, and is reusable by hazard-detection logic.

Test Plan:
- ADDIU $5, result 0x0000002A, in_valid one cycle -> next edge out_valid=1, out_data=0x2A, out_dest=5, out_reg_write=1, stall never 1.
- LW rt=8, addr 0x00000100, ack with rdata 0xCAFEF00D on the 3rd ACCESS cycle -> dmem_req=1 with addr 0x100 and we=0 for 3 cycles; stall=1 throughout; out_valid next edge with out_data=0xCAFEF00D, out_dest=8, out_reg_write=1.
- SW addr 0x00000200, rt_data 0xDEADBEEF, ack in the first ACCESS cycle -> dmem_we=1, wdata=0xDEADBEEF; out_valid 2 cycles after accept with out_reg_write=0, out_err=0.
- LW addr 0x00000102 -> dmem_req stays 0; next edge out_valid=1, out_err=1, out_reg_write=0.
- LW with ack held low, TIMEOUT_CYCLES=16 -> req high exactly 16 cycles then drops; out_valid=1, out_err=1; the next instruction is accepted.
- Mid-ACCESS reset_n=0 (asynchronous), plus an R-type rd=0 -> dmem_req/stall drop before the next edge with no out_valid; after release the R-type gives out_valid=1, out_reg_write=0.
